// File: rtl/cache_sa_pkg.sv
// Shared types and default geometry for the set-associative FIFO tag unit.
// The top module derives its own geometry from its parameters; the values
// here describe the default build.
package cache_sa_pkg;

  localparam int DEF_CAPACITY     = 128;
  localparam int DEF_ASSOC        = 4;
  localparam int DEF_BW_WORD_ADDR = 24;
  localparam int DEF_BW_BLOCK     = 4;

  localparam int SETS   = DEF_CAPACITY / DEF_ASSOC;
  localparam int BW_SET = $clog2(SETS);
  localparam int BW_WAY = $clog2(DEF_ASSOC);
  localparam int BW_TAG = DEF_BW_WORD_ADDR - DEF_BW_BLOCK - BW_SET;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_MISS_WAIT,
    ST_FLUSH_SCAN,
    ST_FLUSH_WB
  } state_t;

  typedef struct packed {
    logic [BW_TAG-1:0] tag;
    logic              valid;
    logic              dirty;
  } entry_t;

endpackage

// File: rtl/cache_sa_fifo_victim_sel.sv
// Victim way selection for one set: the lowest-index invalid way wins,
// otherwise the FIFO pointer way. Also flags when the chosen way is the
// pointer way so the caller knows to advance the pointer on refill.
module cache_sa_fifo_victim_sel
  import cache_sa_pkg::*;
#(
  parameter int ASSOCIATIVITY = DEF_ASSOC,
  parameter int BW_WAY_P      = $clog2(ASSOCIATIVITY)
) (
  input  logic [ASSOCIATIVITY-1:0] i_valid,
  input  logic [BW_WAY_P-1:0]      i_ptr,
  output logic [BW_WAY_P-1:0]      o_way,
  output logic                     o_is_ptr
);

  logic                w_any_invalid;
  logic [BW_WAY_P-1:0] w_free_way;

  // Priority search from the top down so the lowest invalid index sticks
  always_comb begin
    w_any_invalid = 1'b0;
    w_free_way    = '0;
    for (int w = ASSOCIATIVITY - 1; w >= 0; w--) begin
      if (!i_valid[w]) begin
        w_any_invalid = 1'b1;
        w_free_way    = BW_WAY_P'(w);
      end
    end
  end

  assign o_way    = w_any_invalid ? w_free_way : i_ptr;
  assign o_is_ptr = (o_way == i_ptr);

endmodule

// File: rtl/cache_sa_fifo_tag_unit.sv
// Tag/state engine for an N-way set-associative cache with per-set FIFO
// replacement. Resolves lookups, picks the victim on a miss, installs the
// refilled tag and runs bulk flushes.
// Optional feature: define CACHE_SA_FIFO_WRITEBACK_EN to keep dirty bits and
// write back dirty blocks during flush; otherwise the cache is write-through
// and flush clears one whole set per cycle.
module cache_sa_fifo_tag_unit
  import cache_sa_pkg::*;
#(
  parameter int CACHE_BLOCK_CAPACITY = DEF_CAPACITY,
  parameter int ASSOCIATIVITY        = DEF_ASSOC,
  parameter int BW_WORD_ADDR         = DEF_BW_WORD_ADDR,
  parameter int BW_BLOCK             = DEF_BW_BLOCK
) (
  input  logic                                    clock_i,
  input  logic                                    resetn_i,
  input  logic                                    req_i,
  input  logic                                    rw_i,
  input  logic [BW_WORD_ADDR-1:0]                 add_i,
  input  logic                                    flush_i,
  input  logic                                    fill_i,
  input  logic                                    wb_ack_i,
  output logic                                    ready_o,
  output logic                                    done_o,
  output logic                                    hit_o,
  output logic                                    miss_o,
  output logic [$clog2(CACHE_BLOCK_CAPACITY)-1:0] block_add_o,
  output logic                                    victim_valid_o,
  output logic                                    victim_dirty_o,
  output logic [BW_WORD_ADDR-BW_BLOCK-1:0]        victim_add_o,
  output logic                                    wb_o,
  output logic                                    flushing_o
);

  localparam int L_SETS   = CACHE_BLOCK_CAPACITY / ASSOCIATIVITY;
  localparam int L_BW_SET = $clog2(L_SETS);
  localparam int L_BW_WAY = $clog2(ASSOCIATIVITY);
  localparam int L_BW_CAP = $clog2(CACHE_BLOCK_CAPACITY);
  localparam int L_BW_BLK = BW_WORD_ADDR - BW_BLOCK;
  localparam int L_BW_TAG = L_BW_BLK - L_BW_SET;

  state_t                    r_state;
  logic [L_BW_TAG-1:0]       r_tag [CACHE_BLOCK_CAPACITY];
  logic [CACHE_BLOCK_CAPACITY-1:0] r_valid;
  logic [L_BW_WAY-1:0]       r_ptr [L_SETS];
  logic [L_BW_BLK-1:0]       r_blk;
  logic                      r_vis_ptr;
  logic [L_BW_CAP-1:0]       r_flush_idx;
  logic                      r_done;
  logic                      r_hit;
  logic                      r_miss;
  logic [L_BW_CAP-1:0]       r_block_add;
  logic                      r_vvalid;
  logic [L_BW_BLK-1:0]       r_vadd;

  logic [L_BW_SET-1:0]       w_set;
  logic [L_BW_TAG-1:0]       w_tag;
  logic [ASSOCIATIVITY-1:0]  w_set_valid;
  logic [ASSOCIATIVITY-1:0]  w_hit_vec;
  logic                      w_hit;
  logic [L_BW_WAY-1:0]       w_hit_way;
  logic [L_BW_CAP-1:0]       w_hit_idx;
  logic [L_BW_WAY-1:0]       w_vway;
  logic                      w_vis_ptr;
  logic [L_BW_CAP-1:0]       w_vidx;
  logic [L_BW_SET-1:0]       w_fl_set;
  logic                      w_fl_last;
  logic [BW_BLOCK-1:0]       w_unused_word;

  assign w_unused_word = add_i[BW_BLOCK-1:0];
  assign w_set         = r_blk[L_BW_SET-1:0];
  assign w_tag         = r_blk[L_BW_BLK-1 -: L_BW_TAG];
  assign w_fl_set      = r_flush_idx[L_BW_CAP-1 -: L_BW_SET];

  // Parallel tag compare across all ways of the latched set
  generate
    for (genvar gi = 0; gi < ASSOCIATIVITY; gi++) begin : g_way
      assign w_set_valid[gi] = r_valid[{w_set, L_BW_WAY'(gi)}];
      assign w_hit_vec[gi]   = w_set_valid[gi] && (r_tag[{w_set, L_BW_WAY'(gi)}] == w_tag);
    end
  endgenerate

  assign w_hit = |w_hit_vec;

  // Encode the hitting way (at most one way can match a valid tag)
  always_comb begin
    w_hit_way = '0;
    for (int w = 0; w < ASSOCIATIVITY; w++) begin
      if (w_hit_vec[w]) w_hit_way = L_BW_WAY'(w);
    end
  end

  assign w_hit_idx = {w_set, w_hit_way};

  cache_sa_fifo_victim_sel #(
    .ASSOCIATIVITY(ASSOCIATIVITY),
    .BW_WAY_P     (L_BW_WAY)
  ) u_victim_sel (
    .i_valid (w_set_valid),
    .i_ptr   (r_ptr[w_set]),
    .o_way   (w_vway),
    .o_is_ptr(w_vis_ptr)
  );

  assign w_vidx = {w_set, w_vway};

`ifdef CACHE_SA_FIFO_WRITEBACK_EN
  logic [CACHE_BLOCK_CAPACITY-1:0] r_dirty;
  logic                            r_rw;
  logic                            r_vdirty;
  logic                            r_wb;
  logic [L_BW_TAG-1:0]             w_fl_tag;

  assign w_fl_tag       = r_tag[r_flush_idx];
  assign w_fl_last      = &r_flush_idx;
  assign victim_dirty_o = r_vdirty;
  assign wb_o           = r_wb;
`else
  logic [1:0] w_unused_wt;

  assign w_unused_wt    = {wb_ack_i, rw_i};
  assign w_fl_last      = &w_fl_set;
  assign victim_dirty_o = 1'b0;
  assign wb_o           = 1'b0;
`endif

  // Tag storage is written only by a refill and needs no reset
  always_ff @(posedge clock_i) begin
    if (r_state == ST_MISS_WAIT && fill_i) r_tag[r_block_add] <= w_tag;
  end

  // Main control FSM with registered pulse and victim outputs
  always_ff @(posedge clock_i) begin
    if (!resetn_i) begin
      r_state     <= ST_IDLE;
      r_valid     <= '0;
      for (int s = 0; s < L_SETS; s++) r_ptr[s] <= '0;
      r_blk       <= '0;
      r_vis_ptr   <= 1'b0;
      r_flush_idx <= '0;
      r_done      <= 1'b0;
      r_hit       <= 1'b0;
      r_miss      <= 1'b0;
      r_block_add <= '0;
      r_vvalid    <= 1'b0;
      r_vadd      <= '0;
`ifdef CACHE_SA_FIFO_WRITEBACK_EN
      r_dirty     <= '0;
      r_rw        <= 1'b0;
      r_vdirty    <= 1'b0;
      r_wb        <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      r_hit  <= 1'b0;
      r_miss <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (flush_i) begin
            r_flush_idx <= '0;
            r_state     <= ST_FLUSH_SCAN;
          end else if (req_i) begin
            r_blk   <= add_i[BW_WORD_ADDR-1:BW_BLOCK];
`ifdef CACHE_SA_FIFO_WRITEBACK_EN
            r_rw    <= rw_i;
`endif
            r_state <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (w_hit) begin
            r_done      <= 1'b1;
            r_hit       <= 1'b1;
            r_block_add <= w_hit_idx;
`ifdef CACHE_SA_FIFO_WRITEBACK_EN
            if (r_rw) r_dirty[w_hit_idx] <= 1'b1;
`endif
            r_state     <= ST_IDLE;
          end else begin
            r_miss      <= 1'b1;
            r_block_add <= w_vidx;
            r_vis_ptr   <= w_vis_ptr;
            r_vvalid    <= r_valid[w_vidx];
            r_vadd      <= {r_tag[w_vidx], w_set};
`ifdef CACHE_SA_FIFO_WRITEBACK_EN
            r_vdirty    <= r_dirty[w_vidx];
`endif
            r_state     <= ST_MISS_WAIT;
          end
        end
        ST_MISS_WAIT: begin
          if (fill_i) begin
            r_valid[r_block_add] <= 1'b1;
`ifdef CACHE_SA_FIFO_WRITEBACK_EN
            r_dirty[r_block_add] <= r_rw;
            r_vdirty             <= 1'b0;
`endif
            if (r_vis_ptr) r_ptr[w_set] <= r_ptr[w_set] + 1'b1;
            r_vvalid <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= ST_IDLE;
          end
        end
`ifdef CACHE_SA_FIFO_WRITEBACK_EN
        ST_FLUSH_SCAN: begin
          if (r_valid[r_flush_idx] && r_dirty[r_flush_idx]) begin
            r_wb    <= 1'b1;
            r_vadd  <= {w_fl_tag, w_fl_set};
            r_state <= ST_FLUSH_WB;
          end else begin
            r_valid[r_flush_idx] <= 1'b0;
            if (w_fl_last) begin
              for (int s = 0; s < L_SETS; s++) r_ptr[s] <= '0;
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_flush_idx <= r_flush_idx + 1'b1;
            end
          end
        end
        ST_FLUSH_WB: begin
          if (wb_ack_i) begin
            r_wb                 <= 1'b0;
            r_valid[r_flush_idx] <= 1'b0;
            r_dirty[r_flush_idx] <= 1'b0;
            if (w_fl_last) begin
              for (int s = 0; s < L_SETS; s++) r_ptr[s] <= '0;
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_flush_idx <= r_flush_idx + 1'b1;
              r_state     <= ST_FLUSH_SCAN;
            end
          end
        end
`else
        ST_FLUSH_SCAN: begin
          // Nothing to write back, so clear a whole set each cycle
          for (int w = 0; w < ASSOCIATIVITY; w++) begin
            r_valid[{w_fl_set, L_BW_WAY'(w)}] <= 1'b0;
          end
          if (w_fl_last) begin
            for (int s = 0; s < L_SETS; s++) r_ptr[s] <= '0;
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_flush_idx <= r_flush_idx + L_BW_CAP'(ASSOCIATIVITY);
          end
        end
`endif
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ready_o        = (r_state == ST_IDLE);
  assign flushing_o     = (r_state == ST_FLUSH_SCAN) || (r_state == ST_FLUSH_WB);
  assign done_o         = r_done;
  assign hit_o          = r_hit;
  assign miss_o         = r_miss;
  assign block_add_o    = r_block_add;
  assign victim_valid_o = r_vvalid;
  assign victim_add_o   = r_vadd;

endmodule
